// File: rtl/stream_port_hub.sv
// stream_port_hub: N_CH-to-1 round-robin stb/ack stream merger tagging each word with its source,
//   plus OR/sticky aggregation of N_EXC exception lines. Latency 1 cycle in_stb->out_stb, 1 word/cycle.
// Backpressure: output register refills in the same cycle out_ack drains it; with the optional
//   STREAM_PORT_HUB_WATCHDOG_EN build, a word stalled for TIMEOUT cycles is dropped and flagged.
module stream_port_hub #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int N_EXC   = 17,
  parameter int TIMEOUT = 1024,
  localparam int TAG_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_stb,
  output logic [N_CH-1:0]          in_ack,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_stb,
  input  logic                     out_ack,
  input  logic [N_EXC-1:0]         exception_in,
  output logic                     exception,
  output logic [N_EXC:0]           exception_flags
);

  // Parameter range guards, evaluated at elaboration only.
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("stream_port_hub: N_CH must be in 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << 20)) begin : g_bad_timeout
    $error("stream_port_hub: TIMEOUT must be in 1..2^20");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               out_stb_q, out_stb_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_EXC-1:0]   exc_flags_q, exc_flags_d;
  logic               wd_flag;

  logic               grant_vld;
  logic [TAG_W-1:0]   grant_idx;
  logic               can_accept;
  logic               take;
  int                 off;
  int                 best_off;

  // Round-robin pick: the requesting channel with the smallest distance above rr_ptr (with wrap).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    best_off  = N_CH;
    off       = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (k >= int'(rr_ptr_q)) off = k - int'(rr_ptr_q);
      else                     off = k + N_CH - int'(rr_ptr_q);
      if (in_stb[k] && (off < best_off)) begin
        best_off  = off;
        grant_idx = TAG_W'(k);
        grant_vld = 1'b1;
      end
    end
  end

  // The output register can take a word when empty or when its current word leaves this cycle.
  assign can_accept = (state_q == EMPTY) || out_ack;
  assign take       = grant_vld && can_accept;

  // Acknowledge only the granted channel; held low throughout reset.
  always_comb begin
    in_ack = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_ack[k] = !rst && take && (grant_idx == TAG_W'(k));
    end
  end

`ifdef STREAM_PORT_HUB_WATCHDOG_EN
  logic [19:0] wd_q, wd_d;
  logic        wd_flag_q, wd_flag_d;
  logic        wd_fire;

  // Stall counter: runs while a word is held without out_ack; fires on the TIMEOUT-th stalled cycle.
  always_comb begin
    wd_d      = '0;
    wd_flag_d = wd_flag_q;
    wd_fire   = 1'b0;
    if (state_q == FULL && !out_ack) begin
      if (wd_q == 20'(TIMEOUT - 1)) begin
        wd_fire   = 1'b1;
        wd_flag_d = 1'b1;
      end else begin
        wd_d = wd_q + 20'd1;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      wd_flag_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      wd_flag_q <= wd_flag_d;
    end
  end

  assign wd_flag = wd_flag_q;
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
  assign wd_flag = 1'b0;
`endif

  // Next state of the output register, arbitration pointer and sticky exception flags.
  always_comb begin
    state_d     = state_q;
    out_stb_d   = out_stb_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    rr_ptr_d    = rr_ptr_q;
    exc_flags_d = exc_flags_q | exception_in;
    if (take) begin
      state_d    = FULL;
      out_stb_d  = 1'b1;
      out_data_d = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_tag_d  = grant_idx;
      rr_ptr_d   = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == FULL) && (out_ack || wd_fire)) begin
      // Word consumed (or dropped by the watchdog); data/tag keep their last value.
      state_d   = EMPTY;
      out_stb_d = 1'b0;
    end
  end

  // Output register FSM; async reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_stb_q   <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      rr_ptr_q    <= '0;
      exc_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      out_stb_q   <= out_stb_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      rr_ptr_q    <= rr_ptr_d;
      exc_flags_q <= exc_flags_d;
    end
  end

  assign out_stb         = out_stb_q;
  assign out_data        = out_data_q;
  assign out_tag         = out_tag_q;
  assign exception_flags = {wd_flag, exc_flags_q};
  assign exception       = (|exception_in) | (|exception_flags);

endmodule

// File: tb/tb_stream_port_hub.sv
// tb_stream_port_hub: directed checks of arbitration, backpressure, reset, exceptions and watchdog.
// Inputs driven 1 time unit after the rising edge; outputs sampled before the next edge.
module tb_stream_port_hub;
  localparam int N_CH    = 4;
  localparam int DATA_W  = 32;
  localparam int N_EXC   = 17;
  localparam int TIMEOUT = 8;
`ifdef STREAM_PORT_HUB_WATCHDOG_EN
  localparam int BP_CYC  = 6;
`else
  localparam int BP_CYC  = 10;
`endif

  logic                    clk;
  logic                    rst;
  logic [N_CH*DATA_W-1:0]  in_data;
  logic [N_CH-1:0]         in_stb;
  logic [N_CH-1:0]         in_ack;
  logic [DATA_W-1:0]       out_data;
  logic [1:0]              out_tag;
  logic                    out_stb;
  logic                    out_ack;
  logic [N_EXC-1:0]        exception_in;
  logic                    exception;
  logic [N_EXC:0]          exception_flags;

  int errors = 0;
  int checks = 0;

  stream_port_hub #(
    .N_CH(N_CH), .DATA_W(DATA_W), .N_EXC(N_EXC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .out_data(out_data), .out_tag(out_tag), .out_stb(out_stb), .out_ack(out_ack),
    .exception_in(exception_in), .exception(exception), .exception_flags(exception_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_stb = '0; out_ack = 1'b0; exception_in = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    in_data[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_stb = 4'hF; out_ack = 1'b0; exception_in = '0; in_data = '0;
    tick(); tick();
    checks++;
    if ({out_stb, out_tag, out_data, exception_flags, in_ack, exception} !== '0) begin
      errors++;
      $display("FAIL reset_state: stb=%0b tag=%0d data=%h flags=%h ack=%b exc=%0b want all 0",
               out_stb, out_tag, out_data, exception_flags, in_ack, exception);
    end
    // Fill the register and set a sticky flag, then assert reset between edges.
    rst = 1'b0; in_stb = 4'b0010; set_ch(1, 32'h1111_2222); exception_in = 17'h00001;
    tick();
    in_stb = '0; exception_in = '0; #1;
    checks++;
    if ({out_stb, out_tag, exception_flags} !== {1'b1, 2'd1, 18'h00001}) begin
      errors++;
      $display("FAIL reset_prefill: stb=%0b tag=%0d flags=%h want 1 1 00001", out_stb, out_tag, exception_flags);
    end
    #1; rst = 1'b1; in_stb = 4'hF; out_ack = 1'b1; #1;
    checks++;
    if ({out_stb, in_ack, exception_flags} !== '0) begin
      errors++;
      $display("FAIL reset_async: stb=%0b ack=%b flags=%h want 0 0 0", out_stb, in_ack, exception_flags);
    end
    #1; rst = 1'b0; #1;
    checks++;
    if (in_ack !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b want 0001", in_ack);
    end
    tick();
    checks++;
    if ({out_stb, out_tag} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_first_word: stb=%0b tag=%0d want 1 0", out_stb, out_tag);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(0, 32'h0000_00C0); set_ch(1, 32'h0000_00C1); set_ch(2, 32'hDEAD_BEEF); set_ch(3, 32'h0000_00C3);
    in_stb = 4'b0100; out_ack = 1'b1; #1;
    checks++;
    if (in_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: ack=%b want 0100", in_ack);
    end
    tick();
    checks++;
    if ({out_stb, out_tag, out_data} !== {1'b1, 2'd2, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_word: stb=%0b tag=%0d data=%h want 1 2 deadbeef", out_stb, out_tag, out_data);
    end
    in_stb = '0; #1;
    checks++;
    if (in_ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle_ack: ack=%b want 0000", in_ack);
    end
    tick();
    checks++;
    if ({out_stb, out_tag, out_data} !== {1'b0, 2'd2, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_drain: stb=%0b tag=%0d data=%h want 0 2 deadbeef", out_stb, out_tag, out_data);
    end
    // rr_ptr is now 3; a lone request on ch0 exercises the wrap.
    in_stb = 4'b0001; tick();
    out_ack = 1'b0; in_stb = 4'b0010; tick();
    in_stb = '0; tick();
    checks++;
    if ({out_stb, out_tag, out_data} !== {1'b1, 2'd0, 32'h0000_00C0}) begin
      errors++;
      $display("FAIL single_wrap_hold: stb=%0b tag=%0d data=%h want 1 0 000000c0", out_stb, out_tag, out_data);
    end
    out_ack = 1'b1; tick();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL single_dropped_stb: stb=%0b want 0", out_stb);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N_CH; k++) set_ch(k, 32'h1000_0000 + k);
    in_stb = 4'hF; out_ack = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (in_ack !== (4'b0001 << (i % 4))) begin
        errors++;
        $display("FAIL rr_ack[%0d]: ack=%b want %b", i, in_ack, 4'b0001 << (i % 4));
      end
      tick();
      checks++;
      if ({out_stb, out_tag, out_data} !== {1'b1, 2'(i % 4), 32'h1000_0000 + 32'(i % 4)}) begin
        errors++;
        $display("FAIL rr_word[%0d]: stb=%0b tag=%0d data=%h want 1 %0d %h",
                 i, out_stb, out_tag, out_data, i % 4, 32'h1000_0000 + 32'(i % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    // Continues from the round robin: ch3 word held, rr_ptr back at 0.
    out_ack = 1'b0;
    for (int i = 0; i < BP_CYC; i++) begin
      #1;
      checks++;
      if ({in_ack, out_stb, out_tag, out_data} !== {4'b0000, 1'b1, 2'd3, 32'h1000_0003}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ack=%b stb=%0b tag=%0d data=%h want 0000 1 3 10000003",
                 i, in_ack, out_stb, out_tag, out_data);
      end
      tick();
    end
    out_ack = 1'b1; #1;
    checks++;
    if (in_ack !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_ack: ack=%b want 0001", in_ack);
    end
    tick();
    checks++;
    if ({out_stb, out_tag, out_data} !== {1'b1, 2'd0, 32'h1000_0000}) begin
      errors++;
      $display("FAIL bp_release_word: stb=%0b tag=%0d data=%h want 1 0 10000000", out_stb, out_tag, out_data);
    end
    in_stb = '0; tick();
  endtask

  task automatic test_exceptions();
    do_reset();
    checks++;
    if (exception !== 1'b0) begin
      errors++;
      $display("FAIL exc_idle: exception=%0b want 0", exception);
    end
    exception_in = 17'h00020; #1;
    checks++;
    if (exception !== 1'b1) begin
      errors++;
      $display("FAIL exc_comb: exception=%0b want 1", exception);
    end
    tick();
    exception_in = '0; #1;
    checks++;
    if ({exception, exception_flags} !== {1'b1, 18'h00020}) begin
      errors++;
      $display("FAIL exc_sticky: exception=%0b flags=%h want 1 00020", exception, exception_flags);
    end
    exception_in = 17'h10001; tick();
    exception_in = '0; tick(); tick(); tick();
    checks++;
    if ({exception, exception_flags} !== {1'b1, 18'h10021}) begin
      errors++;
      $display("FAIL exc_accum: exception=%0b flags=%h want 1 10021", exception, exception_flags);
    end
    do_reset();
    checks++;
    if ({exception, exception_flags} !== '0) begin
      errors++;
      $display("FAIL exc_clear: exception=%0b flags=%h want 0 0", exception, exception_flags);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_ch(1, 32'h0BAD_F00D);
    in_stb = 4'b0010; out_ack = 1'b0;
    tick();
    in_stb = '0;
    repeat (TIMEOUT - 1) tick();
    checks++;
    if ({out_stb, out_tag, out_data} !== {1'b1, 2'd1, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL wd_pre: stb=%0b tag=%0d data=%h want 1 1 0badf00d", out_stb, out_tag, out_data);
    end
    tick();
`ifdef STREAM_PORT_HUB_WATCHDOG_EN
    checks++;
    if ({out_stb, exception, exception_flags} !== {1'b0, 1'b1, 18'h20000}) begin
      errors++;
      $display("FAIL wd_fire: stb=%0b exception=%0b flags=%h want 0 1 20000", out_stb, exception, exception_flags);
    end
    in_stb = 4'b0100; #1;
    checks++;
    if (in_ack !== 4'b0100) begin
      errors++;
      $display("FAIL wd_regrant: ack=%b want 0100", in_ack);
    end
`else
    repeat (20) tick();
    checks++;
    if ({out_stb, out_tag, exception, exception_flags} !== {1'b1, 2'd1, 1'b0, 18'h00000}) begin
      errors++;
      $display("FAIL wd_absent: stb=%0b tag=%0d exception=%0b flags=%h want 1 1 0 0",
               out_stb, out_tag, exception, exception_flags);
    end
`endif
    in_stb = '0; out_ack = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_exceptions();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
